// File: rtl/exe_muldiv_pkg.sv
// Shared funct3 codes, FSM state encoding and reset constant for the exe_muldiv unit.
package exe_muldiv_pkg;

   localparam logic [2:0] MUL_F3    = 3'b000;
   localparam logic [2:0] MULH_F3   = 3'b001;
   localparam logic [2:0] MULHSU_F3 = 3'b010;
   localparam logic [2:0] MULHU_F3  = 3'b011;
   localparam logic [2:0] DIV_F3    = 3'b100;
   localparam logic [2:0] DIVU_F3   = 3'b101;
   localparam logic [2:0] REM_F3    = 3'b110;
   localparam logic [2:0] REMU_F3   = 3'b111;

   localparam logic MULDIV_ZERO = 1'b0;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StMul  = 3'd1,
      StDiv  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } muldiv_state_e;

endpackage

// File: rtl/exe_muldiv_div_step.sv
// One restoring radix-2 division step: shifts in the next dividend bit and trial-subtracts.
module exe_muldiv_div_step #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic [DATA_WIDTH-1:0] quo_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic [DATA_WIDTH-1:0] quo_o
);

   logic [DATA_WIDTH:0] trial;
   logic [DATA_WIDTH:0] diff;

   // rem_i < divisor_i always holds, so trial < 2*divisor and a borrow shows up in the MSB.
   always_comb begin
      trial = {rem_i, quo_i[DATA_WIDTH-1]};
      diff  = trial - {1'b0, divisor_i};
      if (!diff[DATA_WIDTH]) begin
         rem_o = diff[DATA_WIDTH-1:0];
         quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
      end else begin
         rem_o = trial[DATA_WIDTH-1:0];
         quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit; define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module exe_muldiv
   import exe_muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned RADDR_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic [2:0]             funct3_i,
   input  logic [DATA_WIDTH-1:0]  op1_i,
   input  logic [DATA_WIDTH-1:0]  op2_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   kill_i,
   output logic                   stall_o,
   output logic                   valid_o,
   output logic                   reg_we_o,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

   muldiv_state_e          state_q, state_d;
   logic [2:0]             f3_q, f3_d;
   logic                   neg_q, neg_d;
   logic                   rem_neg_q, rem_neg_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [2*W-1:0]         acc_q, acc_d;
   logic [W-1:0]           opa_q, opa_d;
   logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [RADDR_WIDTH-1:0] out_waddr_q, out_waddr_d;
   logic [W-1:0]           wdata_q, wdata_d;
   logic                   valid_q, valid_d;

   logic           accept, op1_signed, op2_signed, div_zero, div_ovf, special;
   logic [W-1:0]   abs1, abs2, most_neg;
   logic [W:0]     mul_sum;
   logic [W-1:0]   step_rem, step_quo;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix;

   assign most_neg   = {1'b1, {(W-1){1'b0}}};
   assign accept     = start_i & ((state_q == StIdle) | (state_q == StDone));
   assign op1_signed = funct3_i inside {MULH_F3, MULHSU_F3, DIV_F3, REM_F3};
   assign op2_signed = funct3_i inside {MULH_F3, DIV_F3, REM_F3};
   assign abs1       = (op1_signed && op1_i[W-1]) ? -op1_i : op1_i;
   assign abs2       = (op2_signed && op2_i[W-1]) ? -op2_i : op2_i;
   assign div_zero   = (op2_i == '0);
   assign div_ovf    = ~funct3_i[0] & (op1_i == most_neg) & (op2_i == '1);
   assign special    = funct3_i[2] & (div_zero | div_ovf);

   // Combinational on start_i so the issuing instruction itself is held.
   assign stall_o = (state_q inside {StMul, StDiv, StFix}) | (accept & ~special);

   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
   assign rem_fix  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

   exe_muldiv_div_step #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_div_step (
      .rem_i    (acc_q[2*W-1:W]),
      .quo_i    (acc_q[W-1:0]),
      .divisor_i(opa_q),
      .rem_o    (step_rem),
      .quo_o    (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      neg_d       = neg_q;
      rem_neg_d   = rem_neg_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opa_d       = opa_q;
      waddr_d     = waddr_q;
      out_waddr_d = out_waddr_q;
      wdata_d     = wdata_q;
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start_i) begin
               f3_d      = funct3_i;
               neg_d     = (op1_signed & op1_i[W-1]) ^ (op2_signed & op2_i[W-1]);
               rem_neg_d = op1_signed & op1_i[W-1];
               waddr_d   = reg_waddr_i;
               cnt_d     = CntW'(DATA_WIDTH);
               if (special) begin
                  state_d     = StDone;
                  out_waddr_d = reg_waddr_i;
                  if (div_zero) wdata_d = funct3_i[1] ? op1_i : '1;
                  else          wdata_d = funct3_i[1] ? '0 : op1_i;
               end else if (funct3_i[2]) begin
                  state_d = StDiv;
                  opa_d   = abs2;
                  acc_d   = {{W{1'b0}}, abs1};
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  state_d = StFix;
                  acc_d   = {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2};
`else
                  state_d = StMul;
                  opa_d   = abs1;
                  acc_d   = {{W{1'b0}}, abs2};
`endif
               end
            end
         end
         StMul: begin
            acc_d = {mul_sum, acc_q[W-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) state_d = StFix;
         end
         StDiv: begin
            acc_d = {step_rem, step_quo};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) state_d = StFix;
         end
         StFix: begin
            state_d     = StDone;
            out_waddr_d = waddr_q;
            if (f3_q[2])                wdata_d = f3_q[1] ? rem_fix : quo_fix;
            else if (f3_q[1:0] == 2'b00) wdata_d = prod_fix[W-1:0];
            else                        wdata_d = prod_fix[2*W-1:W];
         end
         default: state_d = StIdle;
      endcase
      // Flush wins over both a new start and completion.
      if (kill_i) begin
         state_d     = StIdle;
         wdata_d     = wdata_q;
         out_waddr_d = out_waddr_q;
      end
      valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         f3_q        <= '0;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= {(2*W){MULDIV_ZERO}};
         opa_q       <= {W{MULDIV_ZERO}};
         waddr_q     <= {RADDR_WIDTH{MULDIV_ZERO}};
         out_waddr_q <= {RADDR_WIDTH{MULDIV_ZERO}};
         wdata_q     <= {W{MULDIV_ZERO}};
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         neg_q       <= neg_d;
         rem_neg_q   <= rem_neg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         waddr_q     <= waddr_d;
         out_waddr_q <= out_waddr_d;
         wdata_q     <= wdata_d;
         valid_q     <= valid_d;
      end
   end

   assign valid_o     = valid_q;
   assign reg_we_o    = valid_q;
   assign reg_waddr_o = out_waddr_q;
   assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: directed RV32M cases plus randomized ops against a reference model.
module tb_exe_muldiv;
   import exe_muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = W + 2;
`endif
   localparam int DivLat = W + 2;

   logic        clk_i, rst_n_i, start_i, kill_i;
   logic [2:0]  funct3_i;
   logic [31:0] op1_i, op2_i;
   logic [4:0]  reg_waddr_i;
   logic        stall_o, valid_o, reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  wa;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_exp = '0;

   exe_muldiv #(
      .DATA_WIDTH (32),
      .RADDR_WIDTH(5)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .start_i    (start_i),
      .funct3_i   (funct3_i),
      .op1_i      (op1_i),
      .op2_i      (op2_i),
      .reg_waddr_i(reg_waddr_i),
      .kill_i     (kill_i),
      .stall_o    (stall_o),
      .valid_o    (valid_o),
      .reg_we_o   (reg_we_o),
      .reg_waddr_o(reg_waddr_o),
      .reg_wdata_o(reg_wdata_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] xa, xb, p;
      int sa, sb;
      sa = a;
      sb = b;
      xa = (f3 == MULHU_F3) ? {32'b0, a} : {{32{a[31]}}, a};
      xb = (f3 == MUL_F3 || f3 == MULH_F3) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      case (f3)
         MUL_F3:                      return p[31:0];
         MULH_F3, MULHSU_F3, MULHU_F3: return p[63:32];
         DIV_F3: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         REM_F3: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         DIVU_F3: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && (b == 32'd0 ||
                       (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(15));
         default: return $urandom;
      endcase
   endfunction

   // Drives start for one cycle from the current (post-edge) time.
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
      funct3_i    = f3;
      op1_i       = a;
      op2_i       = b;
      reg_waddr_i = wa;
      start_i     = 1'b1;
      #1;
      check("stall_issue", stall_o, !is_special(f3, a, b));
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_result(input int exp_lat);
      int cycles, stall_low;
      cycles    = 1;
      stall_low = 0;
      while (valid_o !== 1'b1 && cycles < 100) begin
         if (stall_o !== 1'b1) stall_low++;
         @(posedge clk_i);
         #1;
         cycles++;
      end
      check("latency", cycles, exp_lat);
      check("stall_busy_low_cycles", stall_low, 0);
      check("stall_in_done", stall_o, 1'b0);
   endtask

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] exp);
      int lat;
      sb_q.push_back('{data: exp, wa: wa});
      last_exp = exp;
      lat = is_special(f3, a, b) ? 1 : (f3[2] ? DivLat : MulLat);
      launch(f3, a, b, wa);
      wait_result(lat);
   endtask

   always @(negedge clk_i) begin
      if (rst_n_i && (valid_o || reg_we_o)) begin
         check("we_eq_valid", reg_we_o, valid_o);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=%0h required=none", reg_wdata_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("wdata", reg_wdata_o, e.data);
            check("waddr", reg_waddr_o, e.wa);
         end
      end
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  wa;
      rst_n_i = 1'b0;
      start_i = 1'b0;
      kill_i  = 1'b0;
      funct3_i = '0;
      op1_i = '0;
      op2_i = '0;
      reg_waddr_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", valid_o, 1'b0);
      check("rst_we", reg_we_o, 1'b0);
      check("rst_stall", stall_o, 1'b0);
      check("rst_waddr", reg_waddr_o, 5'd0);
      check("rst_wdata", reg_wdata_o, 32'd0);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      do_op(MUL_F3, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
      @(posedge clk_i); #1;
      do_op(MULH_F3, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
      @(posedge clk_i); #1;
      do_op(MULHU_F3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
      @(posedge clk_i); #1;
      do_op(MULHSU_F3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
      @(posedge clk_i); #1;
      do_op(DIV_F3, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
      @(posedge clk_i); #1;
      do_op(REM_F3, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
      @(posedge clk_i); #1;
      do_op(DIVU_F3, 32'd100, 32'd7, 5'd7, 32'd14);
      @(posedge clk_i); #1;
      do_op(REMU_F3, 32'd100, 32'd7, 5'd8, 32'd2);
      @(posedge clk_i); #1;
      do_op(DIV_F3, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
      @(posedge clk_i); #1;
      do_op(REM_F3, 32'd5, 32'd0, 5'd10, 32'd5);
      @(posedge clk_i); #1;
      do_op(DIV_F3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
      @(posedge clk_i); #1;
      do_op(REM_F3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
      @(posedge clk_i); #1;

      // Back-to-back: second start lands in the DONE cycle of the first.
      do_op(MULHU_F3, 32'd3, 32'd5, 5'd13, 32'd0);
      do_op(DIVU_F3, 32'd1000, 32'd9, 5'd14, 32'd111);
      do_op(REMU_F3, 32'd10, 32'd0, 5'd15, 32'd10);
      @(posedge clk_i); #1;

      // Flush at cycle 10 of a divide.
      launch(DIV_F3, 32'd1000, 32'd7, 5'd20);
      repeat (9) @(posedge clk_i);
      #1;
      kill_i = 1'b1;
      @(posedge clk_i);
      #1;
      kill_i = 1'b0;
      check("kill_idle_stall", stall_o, 1'b0);
      check("kill_no_valid", valid_o, 1'b0);
      repeat (40) @(posedge clk_i);
      #1;
      check("kill_wdata_hold", reg_wdata_o, last_exp);

      // Asynchronous reset mid-divide.
      launch(DIVU_F3, 32'd12345, 32'd11, 5'd21);
      repeat (5) @(posedge clk_i);
      #1;
      rst_n_i = 1'b0;
      #1;
      check("arst_valid", valid_o, 1'b0);
      check("arst_we", reg_we_o, 1'b0);
      check("arst_stall", stall_o, 1'b0);
      check("arst_waddr", reg_waddr_o, 5'd0);
      check("arst_wdata", reg_wdata_o, 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      do_op(DIVU_F3, 32'd12345, 32'd11, 5'd22, 32'd1122);
      @(posedge clk_i); #1;

      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(7));
         a  = pick();
         b  = pick();
         wa = 5'($urandom_range(31));
         do_op(f3, a, b, wa, model(f3, a, b));
         if ($urandom_range(1) == 1) begin
            @(posedge clk_i);
            #1;
         end
      end

      repeat (5) @(posedge clk_i);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Iterative RV32M multiply/divide unit for the execute stage, serving the M half of the R/M opcode group. Accepts one operation per start pulse, holds the pipeline with stall_o while iterating, then presents a one-cycle result with register write-back fields. It is width-parametrised and sits beside the single-cycle R/I datapaths. The stage mux selects its output when valid_o is high.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and >= 8
RADDR_WIDTH, 5, register address width

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  launch operation (sampled in IDLE or DONE)
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  in  DATA_WIDTH  rs1 value
op2_i  in  DATA_WIDTH  rs2 value
reg_waddr_i  in  RADDR_WIDTH  destination register
kill_i  in  1  flush; abandons the in-flight operation
stall_o  out  1  hold the upstream pipeline
valid_o  out  1  result valid, one-cycle pulse
reg_we_o  out  1  equals valid_o
reg_waddr_o  out  RADDR_WIDTH  latched destination
reg_wdata_o  out  DATA_WIDTH  result

Behaviour:
- Reset: state=IDLE; valid_o, reg_we_o and stall_o are 0; reg_waddr_o and reg_wdata_o are 0; the counter and accumulators are 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE with start_i=1:
  - Latch funct3, the operand absolute values (signed ops only), the result-sign flags and reg_waddr_i.
  - Load the counter with DATA_WIDTH.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Division special cases are decided at start and go directly to DONE:
  - Divisor 0: quotient = all ones; remainder = op1_i.
  - Signed overflow (op1_i = most negative, op2_i = -1): quotient = op1_i; remainder = 0.
- MUL: shift-add radix-2 over a 2*DATA_WIDTH product, one bit per cycle. After DATA_WIDTH cycles go to FIX.
- DIV: restoring radix-2, one quotient bit per cycle. After DATA_WIDTH cycles go to FIX.
- FIX (1 cycle):
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the result: MUL = low half; MULH/MULHSU/MULHU = high half.
  - Go to DONE.
- DONE: valid_o=1 and reg_we_o=1 for exactly this cycle.
  - Next state is IDLE, or a new operation if start_i=1 (back-to-back, zero bubble).
  - reg_wdata_o and reg_waddr_o hold their values until the next result.
- Latency, start to valid_o: DATA_WIDTH+2 cycles for normal operations (34 at default); 1 cycle for divide special cases.
- stall_o = (state in MUL/DIV/FIX) OR (start_i AND state in IDLE/DONE), except divide special cases. It is combinational on start_i so the issuing instruction is held.
- start_i in MUL/DIV/FIX is ignored.
- kill_i=1 in any state: next state is IDLE and valid_o is suppressed. kill_i has priority over start_i and over completion in the same cycle.
- Reset asserted mid-operation: immediate return to IDLE; no valid_o afterwards.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiplies use a single-cycle full-width multiplier registered into FIX. MUL latency is 2 cycles; DIV is unchanged.
- Undefined: iterative shift-add as above. There is no hardware multiplier.

Decomposition:
- defines.v gains:
  - the M funct3 codes (MUL_F3 ... REMU_F3)
  - the state encodings
  - MULDIV_ZERO for the reset value
- DATA_WIDTH and RADDR_WIDTH already exist there.
- One sub-module: exe_muldiv_div_step, a combinational restoring-division step (remainder/quotient in, remainder/quotient out) instantiated inside the DIV path.

Test Plan:
- MUL 7 x -3 (funct3=000): valid_o after 34 cycles; reg_wdata_o=0xFFFFFFEB; stall_o high for cycles 0..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid 1 cycle after start. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Back-to-back: start_i held in the DONE cycle starts the second op with no idle cycle. kill_i at cycle 10 of a DIV -> no valid_o; IDLE next cycle.
- rst_n_i pulsed low mid-DIV -> all outputs 0 asynchronously; the next op completes correctly. Repeat MUL tests with MULDIV_FAST_MUL_EN defined -> latency 2.
